// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: burst/response encodings, FIFO depth and read FSM states shared by the AXI RAM read path
package axi_ram_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RRESP_OKAY  = 2'b00;
    localparam int         FIFO_DEPTH  = 4;
    typedef enum logic {ST_IDLE, ST_BURST} rd_state_t;
endpackage

// File: rtl/ram_rd_fifo.sv
// ram_rd_fifo: 4-entry synchronous FIFO of packed {id, data, last} read beats with occupancy count
module ram_rd_fifo
    import axi_ram_pkg::*;
#(
    parameter int W = 37
) (
    input  logic                          aclk_s,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [W-1:0]                  din,
    input  logic                          pop,
    output logic [W-1:0]                  dout,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    assign dout = mem[rp];
    // storage, pointers and count; simultaneous push and pop leave count unchanged
    always_ff @(posedge aclk_s or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/axi_ram_rd_ctrl.sv
// axi_ram_rd_ctrl: AXI4 read front end of the RAM slave; AXI_RAM_WRAP_BURST_EN enables true WRAP bursts
module axi_ram_rd_ctrl
    import axi_ram_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int RAM_AW = 12
) (
    input  logic              aclk_s,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              ram_rd_req,
    input  logic              ram_rd_ack,
    output logic [RAM_AW-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int LSB = $clog2(DATA_W/8);
    localparam int FW  = ID_W + DATA_W + 1;
    rd_state_t                    state, state_nx;
    logic [ADDR_W-1:0]            addr_q, addr_nx, step;
    logic [7:0]                   beats_left;
    logic [2:0]                   size_q, eff_size;
    logic [1:0]                   burst_q;
    logic [ID_W-1:0]              id_b, id_q;
    logic                         inflight, last_q, credit_ok, ar_fire, rd_fire;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic [FW-1:0]                head;
`ifdef AXI_RAM_WRAP_BURST_EN
    logic [7:0]                   len_q;
    logic [ADDR_W-1:0]            wrap_mask;
    logic                         wrap_ok;
`endif
    assign credit_ok   = (4'(fifo_count) + 4'(inflight)) < 4'(FIFO_DEPTH);
    assign ar_fire     = s_arvalid & s_arready;
    assign rd_fire     = ram_rd_req & ram_rd_ack;
    assign ram_rd_addr = addr_q[RAM_AW+LSB-1:LSB];
    assign s_rvalid    = fifo_count != '0;
    assign s_rresp     = RRESP_OKAY;
    assign {s_rid, s_rdata, s_rlast} = head;
    // state register
    always_ff @(posedge aclk_s or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end
    // accept AR in IDLE; in BURST request beats while the FIFO has room for them
    always_comb begin
        state_nx   = state;
        s_arready  = 1'b0;
        ram_rd_req = 1'b0;
        if (state == ST_IDLE) begin
            s_arready = 1'b1;
            if (s_arvalid) state_nx = ST_BURST;
        end else begin
            ram_rd_req = credit_ok;
            if (credit_ok && ram_rd_ack && beats_left == 8'd0) state_nx = ST_IDLE;
        end
    end
    // next beat address; oversize transfers step by the bus width
    always_comb begin
        eff_size = (size_q > 3'(LSB)) ? 3'(LSB) : size_q;
        step     = ADDR_W'(1) << eff_size;
`ifdef AXI_RAM_WRAP_BURST_EN
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << eff_size) - ADDR_W'(1);
        wrap_ok   = burst_q == BURST_WRAP &&
                    (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
        addr_nx   = (burst_q == BURST_FIXED) ? addr_q :
                    wrap_ok ? ((addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask)) :
                    addr_q + step;
`else
        addr_nx   = (burst_q == BURST_FIXED) ? addr_q : addr_q + step;
`endif
    end
    // burst context capture, per-beat advance and the one-cycle in-flight marker
    always_ff @(posedge aclk_s or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            beats_left <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            id_b       <= '0;
            id_q       <= '0;
            last_q     <= 1'b0;
            inflight   <= 1'b0;
`ifdef AXI_RAM_WRAP_BURST_EN
            len_q      <= '0;
`endif
        end else begin
            inflight <= rd_fire;
            if (ar_fire) begin
                addr_q     <= s_araddr;
                beats_left <= s_arlen;
                size_q     <= s_arsize;
                burst_q    <= s_arburst;
                id_b       <= s_arid;
`ifdef AXI_RAM_WRAP_BURST_EN
                len_q      <= s_arlen;
`endif
            end
            if (rd_fire) begin
                last_q     <= beats_left == 8'd0;
                id_q       <= id_b;
                addr_q     <= addr_nx;
                beats_left <= beats_left - 8'd1;
            end
        end
    end
    ram_rd_fifo #(.W(FW)) u_fifo (
        .aclk_s (aclk_s),
        .rst_n  (rst_n),
        .push   (inflight),
        .din    ({id_q, ram_rdata, last_q}),
        .pop    (s_rvalid & s_rready),
        .dout   (head),
        .count  (fifo_count)
    );
endmodule

// File: tb/tb_axi_ram_rd_ctrl.sv
// tb_axi_ram_rd_ctrl: scoreboard bench for axi_ram_rd_ctrl with a one-cycle-latency RAM model
module tb_axi_ram_rd_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_arid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid, s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast, s_rvalid, s_rready;
    logic        ram_rd_req, ram_rd_ack;
    logic [11:0] ram_rd_addr;
    logic [31:0] ram_rdata = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          ack_cnt = 0;
    logic [36:0] exp_r[$];
    logic [11:0] exp_a[$];

    axi_ram_rd_ctrl dut (
        .aclk_s(clk), .rst_n(rst_n),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .ram_rd_req(ram_rd_req), .ram_rd_ack(ram_rd_ack), .ram_rd_addr(ram_rd_addr),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [11:0] a);
        return {20'hDA7A0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic exp_beat(input logic [3:0] id, input logic [11:0] a, input logic last);
        exp_a.push_back(a);
        exp_r.push_back({id, data_of(a), last});
    endtask

    // RAM returns data the cycle after the granted address
    always @(posedge clk) if (ram_rd_req && ram_rd_ack) ram_rdata <= data_of(ram_rd_addr);

    // address scoreboard: every granted beat must match the next expected word address
    always @(negedge clk) begin
        if (rst_n && ram_rd_req && ram_rd_ack) begin
            ack_cnt++;
            if (exp_a.size() == 0) chk("ram_addr_extra", {52'd0, ram_rd_addr}, 64'hFFF);
            else chk("ram_addr", {52'd0, ram_rd_addr}, {52'd0, exp_a.pop_front()});
        end
    end

    // R scoreboard: every accepted beat must match the next expected {id,data,last}
    always @(negedge clk) begin
        if (rst_n && s_rvalid && s_rready) begin
            chk("r_resp", {62'd0, s_rresp}, 64'd0);
            if (exp_r.size() == 0) chk("r_extra", {27'd0, s_rid, s_rdata, s_rlast}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("r_beat", {27'd0, s_rid, s_rdata, s_rlast}, {27'd0, exp_r.pop_front()});
        end
    end

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int k = 0;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        @(negedge clk);
        while (!s_arready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ar_ready", {63'd0, s_arready}, 64'd1);
        @(posedge clk);
        #1 s_arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_r.size() != 0 || s_rvalid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(exp_r.size()), 64'd0);
        chk("arready_idle", {63'd0, s_arready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arready"}, {63'd0, s_arready}, 64'd1);
        chk({tag, "_rvalid"}, {63'd0, s_rvalid}, 64'd0);
        chk({tag, "_rlast"}, {63'd0, s_rlast}, 64'd0);
        chk({tag, "_rid"}, {60'd0, s_rid}, 64'd0);
        chk({tag, "_rdata"}, {32'd0, s_rdata}, 64'd0);
        chk({tag, "_rresp"}, {62'd0, s_rresp}, 64'd0);
        chk({tag, "_req"}, {63'd0, ram_rd_req}, 64'd0);
        chk({tag, "_addr"}, {52'd0, ram_rd_addr}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        rst_n = 1'b0; s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0;
        s_arsize = '0; s_arburst = '0; s_rready = 1'b1; ram_rd_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // INCR 4 beats from 0x100, with AR-to-first-R latency
        for (int i = 0; i < 4; i++) exp_beat(4'd1, 12'h040 + 12'(i), i == 3);
        do_ar(4'd1, 32'h100, 8'd3, 3'd2, 2'b01);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!s_rvalid && k < 20);
        chk("first_r_latency", 64'(k), 64'd3);
        wait_drain("incr_drain");

        // FIXED 3 beats at 0x20
        for (int i = 0; i < 3; i++) exp_beat(4'd2, 12'h008, i == 2);
        do_ar(4'd2, 32'h20, 8'd2, 3'd2, 2'b00);
        wait_drain("fixed_drain");

        // WRAP 4 beats from 0x38
`ifdef AXI_RAM_WRAP_BURST_EN
        exp_beat(4'd3, 12'h00E, 1'b0); exp_beat(4'd3, 12'h00F, 1'b0);
        exp_beat(4'd3, 12'h00C, 1'b0); exp_beat(4'd3, 12'h00D, 1'b1);
`else
        exp_beat(4'd3, 12'h00E, 1'b0); exp_beat(4'd3, 12'h00F, 1'b0);
        exp_beat(4'd3, 12'h010, 1'b0); exp_beat(4'd3, 12'h011, 1'b1);
`endif
        do_ar(4'd3, 32'h38, 8'd3, 3'd2, 2'b10);
        wait_drain("wrap_drain");

        // backpressure: 8-beat burst with R stalled fills exactly 4 credits
        s_rready = 1'b0;
        base = ack_cnt;
        for (int i = 0; i < 8; i++) exp_beat(4'd4, 12'h080 + 12'(i), i == 7);
        do_ar(4'd4, 32'h200, 8'd7, 3'd2, 2'b01);
        repeat (20) @(negedge clk);
        chk("bp_acks", 64'(ack_cnt - base), 64'd4);
        chk("bp_req_low", {63'd0, ram_rd_req}, 64'd0);
        chk("bp_rvalid", {63'd0, s_rvalid}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_stall_payload", {27'd0, s_rid, s_rdata, s_rlast}, {27'd0, exp_r[0]});
            @(negedge clk);
        end
        @(posedge clk);
        #1 s_rready = 1'b1;
        wait_drain("bp_drain");

        // arbiter denial: grant withheld for 3 cycles
        ram_rd_ack = 1'b0;
        for (int i = 0; i < 4; i++) exp_beat(4'd6, 12'h0C0 + 12'(i), i == 3);
        do_ar(4'd6, 32'h300, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("deny_req", {63'd0, ram_rd_req}, 64'd1);
            chk("deny_addr", {52'd0, ram_rd_addr}, 64'h0C0);
        end
        @(posedge clk);
        #1 ram_rd_ack = 1'b1;
        wait_drain("deny_drain");

        // reset after 2 of 8 beats granted
        base = ack_cnt;
        for (int i = 0; i < 8; i++) exp_beat(4'd7, 12'h100 + 12'(i), i == 7);
        do_ar(4'd7, 32'h400, 8'd7, 3'd2, 2'b01);
        k = 0;
        while (ack_cnt - base < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("mid_acks", 64'(ack_cnt - base), 64'd2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_r.delete();
        exp_a.delete();
        #1 chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_beat(4'd5, 12'h004, 1'b0);
        exp_beat(4'd5, 12'h005, 1'b1);
        do_ar(4'd5, 32'h10, 8'd1, 3'd2, 2'b01);
        wait_drain("post_reset_drain");
        chk("addr_queue_empty", 64'(exp_a.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
